// File: rtl/wisc_pkg.sv
// Shared front-end constants and the fetch-entry layout used between fetch and decode.
package wisc_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0]  HALT_OPC  = 5'b00000;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_inc;
    logic        err;
  } fetch_entry_t;

endpackage

// File: rtl/dff.sv
// Plain register cell used for storage arrays; callers mux their own write enable in front.
module dff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge clk) begin
    o_q <= i_d;
  end

endmodule

// File: rtl/fetch_queue.sv
// Small in-order queue between fetch and decode: flush on redirect, blocks fetch after HALT.
module fetch_queue
  import wisc_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_instr,
  input  logic [WIDTH-1:0] in_pc_inc,
  input  logic             in_err,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc_inc,
  output logic             out_err,
  input  logic             out_ready,
  input  logic             flush,
  output logic             halt_seen
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 2 * WIDTH + 1;

  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_halt_seen;

  logic          w_enq;
  logic          w_deq;
  logic          w_is_halt;
  logic [EW-1:0] w_in_entry;
  logic [EW-1:0] w_head;
  logic [EW-1:0] w_d [DEPTH];
  logic [EW-1:0] w_q [DEPTH];

  // Readiness looks only at registered state so decode stalls never reach fetch combinationally.
  assign in_ready   = (r_count != CW'(DEPTH)) & ~r_halt_seen;
  assign out_valid  = (r_count != '0);
  assign halt_seen  = r_halt_seen;

  assign w_enq      = in_valid & in_ready & ~flush;
  assign w_deq      = out_valid & out_ready & ~flush;
  assign w_is_halt  = (in_instr[WIDTH-1 -: 5] == HALT_OPC);
  assign w_in_entry = {in_instr, in_pc_inc, in_err};

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    assign w_d[g] = (w_enq && (r_wr_ptr == AW'(g))) ? w_in_entry : w_q[g];
    dff #(.WIDTH(EW)) u_entry (
      .clk (clk),
      .i_d (w_d[g]),
      .o_q (w_q[g])
    );
  end

  assign w_head     = w_q[r_rd_ptr];
  assign out_instr  = out_valid ? w_head[EW-1 -: WIDTH] : WIDTH'(NOP_INSTR);
  assign out_pc_inc = out_valid ? w_head[WIDTH:1] : '0;
  assign out_err    = out_valid & w_head[0];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_halt_seen <= 1'b0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_enq && w_is_halt) r_halt_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and random stimulus for fetch_queue, checked against a queue-based model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_instr;
  logic [WIDTH-1:0] in_pc_inc;
  logic             in_err;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_instr;
  logic [WIDTH-1:0] out_pc_inc;
  logic             out_err;
  logic             out_ready;
  logic             flush;
  logic             halt_seen;

  fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_pc_inc  (in_pc_inc),
    .in_err     (in_err),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_instr  (out_instr),
    .out_pc_inc (out_pc_inc),
    .out_err    (out_err),
    .out_ready  (out_ready),
    .flush      (flush),
    .halt_seen  (halt_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic        err;
  } ent_t;

  ent_t        mq[$];
  bit          m_halt;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] seen[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare outputs against the model mid-cycle, then advance the model across the edge.
  task automatic step();
    bit m_ready;
    bit m_valid;
    @(negedge clk);
    m_valid = (mq.size() != 0);
    m_ready = (mq.size() < DEPTH) && !m_halt;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_instr", 32'(out_instr), m_valid ? 32'(mq[0].instr) : 32'h0800);
    check("out_pc_inc", 32'(out_pc_inc), m_valid ? 32'(mq[0].pc) : 32'h0);
    check("out_err", 32'(out_err), m_valid ? 32'(mq[0].err) : 32'h0);
    check("in_ready", 32'(in_ready), 32'(m_ready));
    check("halt_seen", 32'(halt_seen), 32'(m_halt));
    @(posedge clk);
    if (!rst || flush) begin
      mq.delete();
      m_halt = 0;
    end else begin
      if (m_valid && out_ready) begin
        seen.push_back(mq[0].instr);
        void'(mq.pop_front());
      end
      if (in_valid && m_ready) begin
        mq.push_back('{instr: in_instr, pc: in_pc_inc, err: in_err});
        if (in_instr[15:11] == 5'b00000) m_halt = 1;
      end
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [15:0] ins, input logic [15:0] pc,
                       input bit e, input bit ordy, input bit fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc_inc = pc;
    in_err    = e;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 16'h0, 16'h0, 0, 0, 0);
    step();
    step();
    rst = 1'b1;
    step();
    check("reset_instr_nop", 32'(out_instr), 32'h0800);
    check("reset_in_ready", 32'(in_ready), 32'h1);

    // Fill and stall, then drain in order.
    drive(1, 16'h4123, 16'h0002, 0, 0, 0); step();
    drive(1, 16'h4124, 16'h0004, 0, 0, 0); step();
    drive(1, 16'h4125, 16'h0006, 0, 0, 0); step();
    check("full_in_ready", 32'(in_ready), 32'h0);
    drive(0, 16'h0, 16'h0, 0, 1, 0); step(); step(); step();
    check("drain_first", 32'(seen[0]), 32'h4123);
    check("drain_second", 32'(seen[1]), 32'h4124);

    // Streaming at full rate.
    seen.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1, 16'h1000 + 16'(i), 16'h0100 + 16'(2 * i), 0, 1, 0);
      step();
    end
    drive(0, 16'h0, 16'h0, 0, 1, 0); step();
    check("stream_count", 32'(seen.size()), 32'd8);
    for (int i = 0; i < 8 && i < seen.size(); i++)
      check("stream_order", 32'(seen[i]), 32'h1000 + 32'(i));

    // Flush with simultaneous input, then a normal enqueue.
    drive(1, 16'h5001, 16'h0010, 0, 0, 0); step();
    drive(1, 16'h5002, 16'h0012, 0, 0, 0); step();
    drive(1, 16'h2222, 16'h0014, 0, 1, 1); step();
    check("flush_empty", 32'(out_valid), 32'h0);
    drive(1, 16'h3333, 16'h0016, 0, 0, 0); step();
    check("post_flush_instr", 32'(out_instr), 32'h3333);
    drive(0, 16'h0, 16'h0, 0, 1, 0); step(); step();

    // HALT blocks further fetch until a flush.
    drive(1, 16'h4001, 16'h0020, 0, 0, 0); step();
    drive(1, 16'h0000, 16'h0022, 0, 0, 0); step();
    check("halt_set", 32'(halt_seen), 32'h1);
    drive(1, 16'h4444, 16'h0024, 0, 1, 0); step(); step(); step();
    check("halt_blocks", 32'(out_valid), 32'h0);
    drive(0, 16'h0, 16'h0, 0, 0, 1); step();
    drive(0, 16'h0, 16'h0, 0, 0, 0); step();
    check("halt_cleared", 32'(halt_seen), 32'h0);

    // Error flag and mid-operation reset.
    drive(1, 16'h6001, 16'h0030, 1, 0, 0); step();
    check("err_visible", 32'(out_err), 32'h1);
    drive(1, 16'h6002, 16'h0032, 0, 0, 0); step();
    drive(0, 16'h0, 16'h0, 0, 0, 0);
    rst = 1'b0; step();
    rst = 1'b1; step();
    check("mid_reset_valid", 32'(out_valid), 32'h0);

    // Random traffic, including occasional HALTs, flushes and resets.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      if ($urandom_range(0, 15) == 0) ins[15:11] = 5'b00000;
      else if (ins[15:11] == 5'b00000) ins[15] = 1'b1;
      drive(bit'($urandom_range(0, 3) != 0), ins, 16'($urandom), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 19) == 0));
      rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
